// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: tracks pending register writes, blocks RAW/WAW
// hazards, and drains outstanding writes before serializing instructions.
module issue_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic [4:0]       dec_rd,
  input  logic             dec_rd_we,
  input  logic             dec_serialize,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic             issue_ready,
  output logic             issue_fire,
  output logic             stall,
  output logic [NREG-1:0]  busy_vec,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             draining
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t state_q, state_n;

  logic [NREG-1:0] clr_mask, set_mask, eff;
  logic            raw, waw, eff_nz;

  function automatic logic [NREG-1:0] onehot(input logic [4:0] idx);
    logic [NREG-1:0] r;
    r = '0;
    for (int i = 0; i < NREG; i++)
      if (int'(idx) == i) r[i] = 1'b1;
    return r;
  endfunction

  // Writeback frees its register for issue in the same cycle.
  assign clr_mask = wb_valid ? onehot(wb_rd) : '0;
  assign eff      = busy_vec & ~clr_mask;
  assign eff_nz   = |eff;
  assign raw      = (dec_use_rs1 & |(eff & onehot(dec_rs1))) |
                    (dec_use_rs2 & |(eff & onehot(dec_rs2)));
  assign waw      = dec_rd_we & (dec_rd != 5'd0) & |(eff & onehot(dec_rd));

  assign issue_fire = dec_valid & issue_ready;
  assign stall      = dec_valid & ~issue_ready;
  assign set_mask   = (issue_fire & dec_rd_we & (dec_rd != 5'd0)) ? onehot(dec_rd) : '0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    if (flush) begin
      state_n = RUN;
    end else begin
      case (state_q)
        RUN:     if (dec_valid & dec_serialize & eff_nz) state_n = DRAIN;
        DRAIN:   if (issue_fire | ~dec_valid)            state_n = RUN;
        default: state_n = RUN;
      endcase
    end
  end

  always_comb begin
    issue_ready = 1'b0;
    draining    = 1'b0;
    case (state_q)
      RUN:     issue_ready = ~raw & ~waw & ~flush & ~(dec_serialize & eff_nz);
      DRAIN: begin
        issue_ready = ~eff_nz & ~flush;
        draining    = 1'b1;
      end
      default: issue_ready = 1'b0;
    endcase
  end

  // Set has priority over clear on the same register; flush overrides both.
  always_ff @(posedge clk) begin
    if (rst || flush) busy_vec <= '0;
    else              busy_vec <= (busy_vec & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst)                           stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed vector table, randomized run against a
// behavioural model, and stall-counter saturation plus reset.
module tb_issue_scoreboard;

  localparam int NREG  = 32;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk, rst, dec_valid, dec_use_rs1, dec_use_rs2, dec_rd_we;
  logic             dec_serialize, wb_valid, flush;
  logic [4:0]       dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic             issue_ready, issue_fire, stall, draining;
  logic [NREG-1:0]  busy_vec;
  logic [CNT_W-1:0] stall_cnt;

  issue_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .dec_serialize(dec_serialize),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .issue_ready(issue_ready), .issue_fire(issue_fire), .stall(stall),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt), .draining(draining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_all(input string tag, input bit r, input bit f, input bit s,
                           input logic [31:0] b, input int c, input bit d);
    check({tag, ".issue_ready"}, 64'(issue_ready), 64'(r));
    check({tag, ".issue_fire"},  64'(issue_fire),  64'(f));
    check({tag, ".stall"},       64'(stall),       64'(s));
    check({tag, ".busy_vec"},    64'(busy_vec),    64'(b));
    check({tag, ".stall_cnt"},   64'(stall_cnt),   64'(c));
    check({tag, ".draining"},    64'(draining),    64'(d));
  endtask

  typedef struct {
    bit dv; int rs1; bit u1; int rd; bit we; bit ser; bit wbv; int wbrd; bit fl;
    bit r; bit f; bit s; int busy; int cnt; bit d;
  } vec_t;

  function automatic vec_t mk(bit dv, int rs1, bit u1, int rd, bit we, bit ser,
                              bit wbv, int wbrd, bit fl, bit r, bit f, bit s,
                              int busy, int cnt, bit d);
    vec_t v;
    v.dv = dv; v.rs1 = rs1; v.u1 = u1; v.rd = rd; v.we = we; v.ser = ser;
    v.wbv = wbv; v.wbrd = wbrd; v.fl = fl;
    v.r = r; v.f = f; v.s = s; v.busy = busy; v.cnt = cnt; v.d = d;
    return v;
  endfunction

  task automatic idle_inputs();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
    dec_rd = 0; dec_rd_we = 0; dec_serialize = 0; wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_hold.issue_ready", 64'(issue_ready), 64'd1);
    check("rst.busy_vec", 64'(busy_vec), 64'd0);
    check("rst.stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst.draining", 64'(draining), 64'd0);
    rst = 0;
  endtask

  // Behavioural model: set of registers with a write in flight, drain mode flag.
  bit pend[32];
  bit m_drain;
  int m_cnt;

  function automatic bit pend_eff(int r);
    return (r != 0) && pend[r] && !(wb_valid && int'(wb_rd) == r);
  endfunction

  function automatic int outstanding();
    int n = 0;
    for (int r = 1; r < 32; r++) if (pend_eff(r)) n++;
    return n;
  endfunction

  function automatic bit model_ready();
    if (m_drain) return (outstanding() == 0) && !flush;
    if (flush) return 0;
    if (dec_use_rs1 && pend_eff(int'(dec_rs1))) return 0;
    if (dec_use_rs2 && pend_eff(int'(dec_rs2))) return 0;
    if (dec_rd_we && pend_eff(int'(dec_rd))) return 0;
    if (dec_serialize && outstanding() > 0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int r = 0; r < 32; r++) b[r] = pend[r];
    return b;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    m_drain = 0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    bit rdy, fire, stl, more;
    rdy  = model_ready();
    fire = dec_valid && rdy;
    stl  = dec_valid && !rdy;
    more = outstanding() > 0;
    if (rst) begin
      model_clear();
    end else begin
      if (stl && m_cnt < CMAX) m_cnt++;
      if (flush) begin
        for (int r = 0; r < 32; r++) pend[r] = 0;
        m_drain = 0;
      end else begin
        if (wb_valid) pend[int'(wb_rd)] = 0;
        if (fire && dec_rd_we && dec_rd != 0) pend[int'(dec_rd)] = 1;
        if (!m_drain) m_drain = dec_valid && dec_serialize && more;
        else          m_drain = !(fire || !dec_valid);
      end
    end
  endtask

  vec_t vecs[$];

  initial begin
    bit er;
    rst = 1;
    idle_inputs();

    vecs.push_back(mk(1,0,0,5,1,0,0,0,0, 1,1,0,'h000,0,0));
    vecs.push_back(mk(1,5,1,0,0,0,0,0,0, 0,0,1,'h020,0,0));
    vecs.push_back(mk(1,5,1,0,0,0,1,5,0, 1,1,0,'h020,1,0));
    vecs.push_back(mk(1,0,0,5,1,0,0,0,0, 1,1,0,'h000,1,0));
    vecs.push_back(mk(1,0,0,5,1,0,1,5,0, 1,1,0,'h020,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,'h020,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,5,0, 1,0,0,'h020,1,0));
    vecs.push_back(mk(1,0,0,0,1,0,0,0,0, 1,1,0,'h000,1,0));
    vecs.push_back(mk(1,0,1,0,0,0,0,0,0, 1,1,0,'h000,1,0));
    vecs.push_back(mk(1,0,0,2,1,0,0,0,0, 1,1,0,'h000,1,0));
    vecs.push_back(mk(1,0,0,3,1,0,0,0,0, 1,1,0,'h004,1,0));
    vecs.push_back(mk(1,0,0,0,0,1,0,0,0, 0,0,1,'h00C,1,0));
    vecs.push_back(mk(1,0,0,0,0,1,1,2,0, 0,0,1,'h00C,2,1));
    vecs.push_back(mk(1,0,0,0,0,1,1,3,0, 1,1,0,'h008,3,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,'h000,3,0));
    vecs.push_back(mk(1,0,0,4,1,0,0,0,0, 1,1,0,'h000,3,0));
    vecs.push_back(mk(1,0,0,5,1,0,0,0,0, 1,1,0,'h010,3,0));
    vecs.push_back(mk(1,0,0,6,1,0,0,0,0, 1,1,0,'h030,3,0));
    vecs.push_back(mk(1,0,0,7,1,0,0,0,0, 1,1,0,'h070,3,0));
    vecs.push_back(mk(1,0,0,0,0,1,0,0,0, 0,0,1,'h0F0,3,0));
    vecs.push_back(mk(1,0,0,0,0,1,0,0,1, 0,0,1,'h0F0,4,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,'h000,5,0));
    vecs.push_back(mk(1,0,0,9,1,0,0,0,0, 1,1,0,'h000,5,0));
    vecs.push_back(mk(1,0,0,0,0,1,0,0,0, 0,0,1,'h200,5,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,'h200,6,1));
    vecs.push_back(mk(0,0,0,0,0,0,1,9,0, 1,0,0,'h200,6,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,'h000,6,0));
    vecs.push_back(mk(1,0,0,9,1,0,0,0,0, 1,1,0,'h000,6,0));
    vecs.push_back(mk(1,0,0,9,1,0,0,0,0, 0,0,1,'h200,6,0));
    vecs.push_back(mk(1,0,0,9,1,0,1,9,0, 1,1,0,'h200,7,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,9,0, 1,0,0,'h200,7,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,12,0,1,0,0,'h000,7,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,'h000,7,0));
    vecs.push_back(mk(1,0,0,3,1,0,0,0,1, 0,0,1,'h000,7,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,'h000,8,0));

    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      dec_valid = vecs[i].dv; dec_rs1 = 5'(vecs[i].rs1); dec_use_rs1 = vecs[i].u1;
      dec_rs2 = 0; dec_use_rs2 = 0;
      dec_rd = 5'(vecs[i].rd); dec_rd_we = vecs[i].we; dec_serialize = vecs[i].ser;
      wb_valid = vecs[i].wbv; wb_rd = 5'(vecs[i].wbrd); flush = vecs[i].fl;
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].r, vecs[i].f, vecs[i].s,
                32'(vecs[i].busy), vecs[i].cnt, vecs[i].d);
    end

    // Randomized run against the model.
    do_reset();
    model_clear();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rst           = ($urandom_range(0, 99) == 0);
      flush         = ($urandom_range(0, 24) == 0);
      dec_valid     = ($urandom_range(0, 4) != 0);
      dec_rs1       = 5'($urandom_range(0, 7));
      dec_rs2       = 5'($urandom_range(0, 7));
      dec_use_rs1   = 1'($urandom_range(0, 1));
      dec_use_rs2   = 1'($urandom_range(0, 1));
      dec_rd        = 5'($urandom_range(0, 7));
      dec_rd_we     = 1'($urandom_range(0, 1));
      dec_serialize = ($urandom_range(0, 5) == 0);
      wb_valid      = 1'($urandom_range(0, 1));
      wb_rd         = 5'($urandom_range(0, 7));
      #1;
      er = model_ready();
      check_all($sformatf("rnd%0d", c), er, dec_valid && er, dec_valid && !er,
                model_busy(), m_cnt, m_drain);
      model_step();
    end
    rst = 0;

    // Stall-counter saturation, then reset clears everything.
    do_reset();
    @(negedge clk);
    dec_valid = 1; dec_rd = 5'd5; dec_rd_we = 1;
    @(negedge clk);
    dec_rd_we = 0; dec_rd = 0; dec_use_rs1 = 1; dec_rs1 = 5'd5;
    repeat ((1 << CNT_W) + 3) @(negedge clk);
    #1;
    check("sat.stall", 64'(stall), 64'd1);
    check("sat.stall_cnt", 64'(stall_cnt), 64'(CMAX));
    rst = 1;
    flush = 1;
    wb_valid = 1; wb_rd = 5'd7;
    @(negedge clk);
    rst = 0;
    idle_inputs();
    #1;
    check_all("post_rst", 1, 0, 0, 32'd0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning the number of architectural registers; register index width is 5.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the stall-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port dec_valid, input, 1, meaning decode presents an instruction.
REQ-006 SHALL have ports dec_rs1/dec_rs2, input, 5 each, meaning the source register indices.
REQ-007 SHALL have ports dec_use_rs1/dec_use_rs2, input, 1 each, meaning the source is actually read.
REQ-008 SHALL have port dec_rd, input, 5, meaning the destination index, and port dec_rd_we, input, 1, meaning the instruction writes rd.
REQ-009 SHALL have port dec_serialize, input, 1, meaning the instruction (fence/CSR) must issue with no writes outstanding.
REQ-010 SHALL have ports wb_valid, input, 1, and wb_rd, input, 5, meaning an execute-stage writeback completes this cycle.
REQ-011 SHALL have port flush, input, 1, meaning all outstanding work is squashed.
REQ-012 SHALL have outputs issue_ready (1, decode may advance), issue_fire (1, dec_valid & issue_ready), stall (1, dec_valid & ~issue_ready), busy_vec (NREG, pending-write bits), stall_cnt (CNT_W, stall cycles), draining (1, FSM in DRAIN).

Function
REQ-013 SHALL keep busy_vec[0] permanently 0; an rd of 0 never sets busy and never causes WAW stall.
REQ-014 SHALL compute clr_mask = one-hot(wb_rd) when wb_valid, else 0; effective busy eff = busy_vec & ~clr_mask (writeback frees a register for issue in the same cycle).
REQ-015 SHALL flag RAW hazard when (dec_use_rs1 & eff[dec_rs1]) | (dec_use_rs2 & eff[dec_rs2]).
REQ-016 SHALL flag WAW hazard when dec_rd_we & dec_rd!=0 & eff[dec_rd].
REQ-017 SHALL implement FSM states RUN and DRAIN; reset state RUN.
REQ-018 In RUN: issue_ready = ~RAW & ~WAW & ~flush & ~(dec_serialize & (eff != 0)).
REQ-019 In RUN, dec_valid & dec_serialize & (eff != 0) & ~flush SHALL transition to DRAIN next cycle.
REQ-020 In DRAIN: issue_ready = (eff == 0) & ~flush; on issue_fire return to RUN next cycle; remain in DRAIN otherwise; dec_valid dropping in DRAIN SHALL return to RUN.
REQ-021 issue_ready, issue_fire, stall SHALL be combinational from inputs and registered state (zero-cycle issue latency).
REQ-022 Next busy_vec SHALL be (busy_vec & ~clr_mask) | set_mask, set_mask = one-hot(dec_rd) when issue_fire & dec_rd_we & dec_rd!=0; set wins when wb_rd equals issuing dec_rd in the same cycle.
REQ-023 wb_valid to a register not busy SHALL be ignored (no state change, no error).
REQ-024 flush SHALL clear busy_vec to 0 and force FSM to RUN next cycle; issue_ready is 0 during the flush cycle; flush overrides set and clear.
REQ-025 stall_cnt SHALL increment by 1 each cycle stall=1, saturate at all-ones, and not be cleared by flush.
REQ-026 draining SHALL be 1 exactly while the FSM is in DRAIN.

Reset
REQ-027 On rst=1 at a clock edge: busy_vec=0, stall_cnt=0, FSM=RUN, draining=0; rst overrides flush, wb and issue in that cycle.
REQ-028 While rst is held, combinational outputs SHALL follow REQ-018 using the reset state (issue_ready=1 when no flush).

Verification
REQ-029 Issue rd=5 (we) cycle 0; cycle 1 dec_use_rs1, rs1=5 -> stall=1, busy_vec=0x20; wb_valid wb_rd=5 in cycle 2 -> issue_fire=1 in cycle 2, stall_cnt=1.
REQ-030 busy_vec=0x20; same cycle wb_rd=5 and issue dec_rd=5 -> issue_fire=1, busy_vec stays 0x20 next cycle.
REQ-031 Issue dec_rd=0 with dec_rd_we=1, then rs1=0 -> busy_vec=0, no stall.
REQ-032 busy_vec=0x0C, dec_serialize=1 -> DRAIN, draining=1; wb 2 then wb 3 -> issue_fire in wb-3 cycle, RUN next cycle, stall_cnt=2.
REQ-033 busy_vec=0xF0 in DRAIN, flush=1 -> issue_ready=0 that cycle; next cycle busy_vec=0, draining=0, stall_cnt retained.
REQ-034 Drive stall for 2^CNT_W+3 cycles -> stall_cnt=all-ones; rst=1 -> all outputs at REQ-027 values next cycle.
